ula_sched: RTL

Round-robin scheduler that shares the single registered ALU (ula_3bits) between two requesters, e.g. the fetch/execute unit and a debug/IO port. Accepts one operation at a time over a valid/ready handshake, drives op/a/b to the ALU, waits out the ALU's 1-cycle registered latency, captures result and sign, and returns them to the owning requester with valid/ready. Sits between the processor control path and the ALU instance.

---
 rtl/ula_sched.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ula_sched.sv
// Round-robin arbiter that shares one registered ALU between two requesters.
// Optional per-requester statistics counters are enabled by defining ULA_SCHED_STATS_EN.
module ula_sched #(
    parameter int OP_W  = 4,
    parameter int D_W   = 4,
    parameter int RES_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [D_W-1:0]   req0_a,
    input  logic [D_W-1:0]   req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [D_W-1:0]   req1_a,
    input  logic [D_W-1:0]   req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [RES_W-1:0] rsp_data,
    output logic             rsp_sinal,
    output logic             rsp_err,
    output logic [OP_W-1:0]  ula_op,
    output logic [D_W-1:0]   ula_a,
    output logic [D_W-1:0]   ula_b,
    input  logic [RES_W-1:0] ula_out,
    input  logic             ula_sinal
`ifdef ULA_SCHED_STATS_EN
    ,
    output logic [7:0]       stat0_cnt,
    output logic [7:0]       stat1_cnt,
    output logic [7:0]       stat_err_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [OP_W-1:0]  ula_op_q, ula_op_d;
    logic [D_W-1:0]   a_q, a_d;
    logic [D_W-1:0]   b_q, b_d;
    logic [RES_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_sinal_q, rsp_sinal_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;

    logic             grant_s;
    logic             any_valid_s;
    logic             accept_s;
    logic             owner_ready_s;
    logic             rsp_done_s;
    logic [OP_W-1:0]  sel_op_s;
    logic [D_W-1:0]   sel_a_s;
    logic [D_W-1:0]   sel_b_s;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op != {OP_W{1'b0}}) && (op <= OP_W'(7));
    endfunction

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign any_valid_s   = req0_valid | req1_valid;
    assign accept_s      = (state_q == IDLE) && any_valid_s;
    assign req0_ready    = (state_q == IDLE) && req0_valid && !grant_s;
    assign req1_ready    = (state_q == IDLE) && req1_valid && grant_s;
    assign sel_op_s      = grant_s ? req1_op : req0_op;
    assign sel_a_s       = grant_s ? req1_a  : req0_a;
    assign sel_b_s       = grant_s ? req1_b  : req0_b;
    assign owner_ready_s = owner_q ? rsp1_ready : rsp0_ready;
    assign rsp_done_s    = (state_q == RESP) && owner_ready_s;

    // Next-state and datapath update for the issue/wait/response sequence.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ula_op_d     = ula_op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_data_d   = rsp_data_q;
        rsp_sinal_d  = rsp_sinal_q;
        rsp_err_d    = rsp_err_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    a_d          = sel_a_s;
                    b_d          = sel_b_s;
                    if (op_is_legal(sel_op_s)) begin
                        ula_op_d = sel_op_s;
                        state_d  = ISSUE;
                    end else begin
                        // Illegal opcodes never touch the ALU and answer immediately.
                        ula_op_d     = {OP_W{1'b0}};
                        rsp_data_d   = {RES_W{1'b0}};
                        rsp_sinal_d  = 1'b0;
                        rsp_err_d    = 1'b1;
                        rsp0_valid_d = ~grant_s;
                        rsp1_valid_d = grant_s;
                        state_d      = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                ula_op_d = {OP_W{1'b0}};
                state_d  = WAIT;
            end
            WAIT: begin
                rsp_data_d   = ula_out;
                rsp_sinal_d  = ula_sinal;
                rsp_err_d    = 1'b0;
                rsp0_valid_d = ~owner_q;
                rsp1_valid_d = owner_q;
                state_d      = RESP;
            end
            RESP: begin
                if (owner_ready_s) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                ula_op_d     = {OP_W{1'b0}};
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ula_op_q     <= {OP_W{1'b0}};
            a_q          <= {D_W{1'b0}};
            b_q          <= {D_W{1'b0}};
            rsp_data_q   <= {RES_W{1'b0}};
            rsp_sinal_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ula_op_q     <= ula_op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_sinal_q  <= rsp_sinal_d;
            rsp_err_q    <= rsp_err_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign ula_op     = ula_op_q;
    assign ula_a      = a_q;
    assign ula_b      = b_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_sinal  = rsp_sinal_q;
    assign rsp_err    = rsp_err_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;

`ifdef ULA_SCHED_STATS_EN
    logic [7:0] stat0_q, stat0_d;
    logic [7:0] stat1_q, stat1_d;
    logic [7:0] stat_err_q, stat_err_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    // Statistics: completed responses per owner and illegal opcodes accepted.
    always_comb begin
        stat0_d    = stat0_q;
        stat1_d    = stat1_q;
        stat_err_d = stat_err_q;
        if (rsp_done_s) begin
            if (owner_q) begin
                stat1_d = sat_inc(stat1_q);
            end else begin
                stat0_d = sat_inc(stat0_q);
            end
        end else begin
            stat0_d = stat0_q;
        end
        if (accept_s && !op_is_legal(sel_op_s)) begin
            stat_err_d = sat_inc(stat_err_q);
        end else begin
            stat_err_d = stat_err_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat0_q    <= 8'd0;
            stat1_q    <= 8'd0;
            stat_err_q <= 8'd0;
        end else begin
            stat0_q    <= stat0_d;
            stat1_q    <= stat1_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat0_cnt    = stat0_q;
    assign stat1_cnt    = stat1_q;
    assign stat_err_cnt = stat_err_q;
`else
    logic unused_s;
    assign unused_s = rsp_done_s;
`endif

endmodule
